masked_affine_pipe: RTL



---
 rtl/masked_affine_pipe.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/masked_affine_pipe.sv
// Three-share nibble affine stage (A1 / A2 / identity) in front of a DEPTH-deep elastic valid/ready pipeline.
// Optional share refresh after the map is enabled by defining MASKED_AFFINE_REFRESH_EN.
module masked_affine_pipe #(
  parameter int NIBBLES = 16,
  parameter int DEPTH   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [4*NIBBLES-1:0]   in_s0,
  input  logic [4*NIBBLES-1:0]   in_s1,
  input  logic [4*NIBBLES-1:0]   in_s2,
`ifdef MASKED_AFFINE_REFRESH_EN
  input  logic [8*NIBBLES-1:0]   in_rnd,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_mode,
  output logic [4*NIBBLES-1:0]   out_s0,
  output logic [4*NIBBLES-1:0]   out_s1,
  output logic [4*NIBBLES-1:0]   out_s2,
  output logic                   busy
);

  localparam int W = 4*NIBBLES;

  // c is the complement bit: 1 only for share 0, so the shares XOR to the unmasked map.
  function automatic logic [3:0] f_nib(input logic [3:0] x, input logic [1:0] m, input logic c);
    case (m)
      2'b00:   f_nib = {x[2]^x[1]^c, x[3]^x[0], x[0]^x[2]^c, x[1]};
      2'b01:   f_nib = {x[3]^x[0]^c, x[2], x[3]^x[1], x[3]^c};
      default: f_nib = x;
    endcase
  endfunction

  function automatic logic [W-1:0] f_word(input logic [W-1:0] s, input logic [1:0] m, input logic c);
    f_word = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      f_word[4*k +: 4] = f_nib(s[4*k +: 4], m, c);
    end
  endfunction

  logic [W-1:0] w_m0, w_m1, w_m2;
  logic [W-1:0] w_d0, w_d1, w_d2;

  assign w_m0 = f_word(in_s0, in_mode, 1'b1);
  assign w_m1 = f_word(in_s1, in_mode, 1'b0);
  assign w_m2 = f_word(in_s2, in_mode, 1'b0);

`ifdef MASKED_AFFINE_REFRESH_EN
  logic [W-1:0] w_r0, w_r1;
  assign w_r0 = in_rnd[W-1:0];
  assign w_r1 = in_rnd[2*W-1:W];
  assign w_d0 = w_m0 ^ w_r0 ^ w_r1;
  assign w_d1 = w_m1 ^ w_r0;
  assign w_d2 = w_m2 ^ w_r1;
`else
  assign w_d0 = w_m0;
  assign w_d1 = w_m1;
  assign w_d2 = w_m2;
`endif

  logic         r_vld  [DEPTH];
  logic [1:0]   r_mode [DEPTH];
  logic [W-1:0] r_s0   [DEPTH];
  logic [W-1:0] r_s1   [DEPTH];
  logic [W-1:0] r_s2   [DEPTH];

  logic         w_load     [DEPTH];
  logic         w_src_vld  [DEPTH];
  logic [1:0]   w_src_mode [DEPTH];
  logic [W-1:0] w_src_s0   [DEPTH];
  logic [W-1:0] w_src_s1   [DEPTH];
  logic [W-1:0] w_src_s2   [DEPTH];

  // Ready ripples from the output back to stage 0: a stage can load if empty or it moves on this cycle.
  always_comb begin
    logic w_acc;
    w_acc = out_ready;
    for (int i = DEPTH-1; i >= 0; i--) begin
      w_load[i] = !r_vld[i] || w_acc;
      w_acc     = w_load[i];
    end
  end

  assign in_ready = w_load[0] && !flush;

  always_comb begin
    w_src_vld[0]  = in_valid && in_ready;
    w_src_mode[0] = in_mode;
    w_src_s0[0]   = w_d0;
    w_src_s1[0]   = w_d1;
    w_src_s2[0]   = w_d2;
    for (int i = 1; i < DEPTH; i++) begin
      w_src_vld[i]  = r_vld[i-1];
      w_src_mode[i] = r_mode[i-1];
      w_src_s0[i]   = r_s0[i-1];
      w_src_s1[i]   = r_s1[i-1];
      w_src_s2[i]   = r_s2[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld[g]  <= 1'b0;
        r_mode[g] <= 2'b00;
        r_s0[g]   <= '0;
        r_s1[g]   <= '0;
        r_s2[g]   <= '0;
      end else if (flush) begin
        r_vld[g]  <= 1'b0;
      end else if (w_load[g]) begin
        r_vld[g] <= w_src_vld[g];
        if (w_src_vld[g]) begin
          r_mode[g] <= w_src_mode[g];
          r_s0[g]   <= w_src_s0[g];
          r_s1[g]   <= w_src_s1[g];
          r_s2[g]   <= w_src_s2[g];
        end
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy = busy | r_vld[i];
    end
  end

  assign out_valid = r_vld[DEPTH-1];
  assign out_mode  = r_mode[DEPTH-1];
  assign out_s0    = r_s0[DEPTH-1];
  assign out_s1    = r_s1[DEPTH-1];
  assign out_s2    = r_s2[DEPTH-1];

endmodule
